// File: rtl/mem_access_unit.sv
// MEM-stage data-memory controller for the pipelined LC-3b: word/byte loads and stores,
// LDI/STI pointer indirection, and a pipeline stall held until the access completes.
module mem_access_unit #(
  parameter int unsigned INDIRECT_GAP = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_valid,
  input  logic [2:0]  mem_op,
  input  logic [15:0] mem_addr,
  input  logic [15:0] mem_wdata,
  output logic        dmem_read,
  output logic        dmem_write,
  output logic [15:0] dmem_address,
  output logic [15:0] dmem_wdata,
  output logic [1:0]  dmem_byte_enable,
  input  logic        dmem_resp,
  input  logic [15:0] dmem_rdata,
  output logic [15:0] mem_rdata,
  output logic        mem_done,
  output logic        stall
);

  typedef enum logic [1:0] {IDLE, PTR, GAP, DATA} state_t;

  localparam logic [2:0] OP_LDW = 3'd1;
  localparam logic [2:0] OP_STW = 3'd2;
  localparam logic [2:0] OP_LDB = 3'd3;
  localparam logic [2:0] OP_STB = 3'd4;
  localparam logic [2:0] OP_LDI = 3'd5;
  localparam logic [2:0] OP_STI = 3'd6;

  localparam logic [1:0] GAP_LOAD = (INDIRECT_GAP > 0) ? 2'(INDIRECT_GAP - 1) : 2'd0;

  state_t      state, state_nxt;
  logic [2:0]  op_q;
  logic [15:0] addr_q, wdata_q, ptr_q, hold_q;
  logic [1:0]  gap_cnt;

  logic        start, is_ind, is_store;
  logic [15:0] tgt, load_val;
  logic [7:0]  load_byte;

  assign start    = mem_valid && (mem_op != 3'd0) && (mem_op != 3'd7);
  assign is_ind   = (op_q == OP_LDI) || (op_q == OP_STI);
  assign is_store = (op_q == OP_STW) || (op_q == OP_STB) || (op_q == OP_STI);
  assign tgt      = is_ind ? ptr_q : addr_q;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // NOTE: every always_comb output gets a default first, so no path leaves it unassigned (no latch).
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (start) state_nxt = ((mem_op == OP_LDI) || (mem_op == OP_STI)) ? PTR : DATA;
      PTR:  if (dmem_resp) state_nxt = (INDIRECT_GAP > 0) ? GAP : DATA;
      GAP:  if (gap_cnt == 2'd0) state_nxt = DATA;
      DATA: if (dmem_resp) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Requests depend only on state and latched values, never on dmem_resp.
  always_comb begin
    dmem_read        = 1'b0;
    dmem_write       = 1'b0;
    dmem_address     = 16'h0000;
    dmem_wdata       = 16'h0000;
    dmem_byte_enable = 2'b00;
    unique case (state)
      PTR: begin
        dmem_read    = 1'b1;
        dmem_address = {addr_q[15:1], 1'b0};
      end
      DATA: begin
        dmem_address     = {tgt[15:1], 1'b0};
        dmem_byte_enable = 2'b11;
        if (is_store) begin
          dmem_write = 1'b1;
          if (op_q == OP_STB) begin
            dmem_wdata       = {wdata_q[7:0], wdata_q[7:0]};
            dmem_byte_enable = tgt[0] ? 2'b10 : 2'b01;
          end else begin
            dmem_wdata = wdata_q;
          end
        end else begin
          dmem_read = 1'b1;
        end
      end
      default: ;
    endcase
  end

  assign load_byte = tgt[0] ? dmem_rdata[15:8] : dmem_rdata[7:0];
  assign load_val  = (op_q == OP_LDB) ? {{8{load_byte[7]}}, load_byte} : dmem_rdata;
  assign mem_done  = (state == DATA) && dmem_resp;
  assign mem_rdata = (mem_done && !is_store) ? load_val : hold_q;
  assign stall     = ((state == IDLE) && start) || ((state != IDLE) && !mem_done);

  always_ff @(posedge clk) begin
    if (reset) begin
      op_q    <= 3'd0;
      addr_q  <= 16'h0000;
      wdata_q <= 16'h0000;
      ptr_q   <= 16'h0000;
      hold_q  <= 16'h0000;
      gap_cnt <= 2'd0;
    end else begin
      if ((state == IDLE) && start) begin
        op_q    <= mem_op;
        addr_q  <= mem_addr;
        wdata_q <= mem_wdata;
      end
      if ((state == PTR) && dmem_resp) begin
        ptr_q   <= dmem_rdata;
        gap_cnt <= GAP_LOAD;
      end
      if ((state == GAP) && (gap_cnt != 2'd0)) gap_cnt <= gap_cnt - 2'd1;
      if (mem_done && !is_store) hold_q <= load_val;
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Randomized bench for mem_access_unit: two instances (INDIRECT_GAP 1 and 0) driven by
// transaction tasks, checked against a word-addressed memory model and per-op rules.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset [2];
  logic        mem_valid [2];
  logic [2:0]  mem_op [2];
  logic [15:0] mem_addr [2];
  logic [15:0] mem_wdata [2];
  logic        dmem_read [2];
  logic        dmem_write [2];
  logic [15:0] dmem_address [2];
  logic [15:0] dmem_wdata [2];
  logic [1:0]  dmem_byte_enable [2];
  logic        dmem_resp [2];
  logic [15:0] dmem_rdata [2];
  logic [15:0] mem_rdata [2];
  logic        mem_done [2];
  logic        stall [2];

  mem_access_unit #(.INDIRECT_GAP(1)) u_gap1 (
    .clk(clk), .reset(reset[0]), .mem_valid(mem_valid[0]), .mem_op(mem_op[0]),
    .mem_addr(mem_addr[0]), .mem_wdata(mem_wdata[0]), .dmem_read(dmem_read[0]),
    .dmem_write(dmem_write[0]), .dmem_address(dmem_address[0]), .dmem_wdata(dmem_wdata[0]),
    .dmem_byte_enable(dmem_byte_enable[0]), .dmem_resp(dmem_resp[0]),
    .dmem_rdata(dmem_rdata[0]), .mem_rdata(mem_rdata[0]), .mem_done(mem_done[0]),
    .stall(stall[0])
  );

  mem_access_unit #(.INDIRECT_GAP(0)) u_gap0 (
    .clk(clk), .reset(reset[1]), .mem_valid(mem_valid[1]), .mem_op(mem_op[1]),
    .mem_addr(mem_addr[1]), .mem_wdata(mem_wdata[1]), .dmem_read(dmem_read[1]),
    .dmem_write(dmem_write[1]), .dmem_address(dmem_address[1]), .dmem_wdata(dmem_wdata[1]),
    .dmem_byte_enable(dmem_byte_enable[1]), .dmem_resp(dmem_resp[1]),
    .dmem_rdata(dmem_rdata[1]), .mem_rdata(mem_rdata[1]), .mem_done(mem_done[1]),
    .stall(stall[1])
  );

  int          n_vec = 0;
  int          n_err = 0;
  logic [15:0] mem_model [logic [15:0]];
  logic [15:0] hold_exp [2];

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Unwritten words read back as an address-derived pattern.
  function automatic logic [15:0] word_at(input logic [15:0] a);
    if (mem_model.exists(a)) return mem_model[a];
    return {a[7:0] ^ 8'h5A, a[15:8] ^ 8'hC3};
  endfunction

  function automatic int gap_of(input int d);
    return (d == 0) ? 1 : 0;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  // Inputs a busy unit must ignore.
  task automatic scramble(input int d);
    mem_valid[d] = 1'($urandom);
    mem_op[d]    = 3'($urandom);
    mem_addr[d]  = 16'($urandom);
    mem_wdata[d] = 16'($urandom);
  endtask

  task automatic run_txn(input int d, input logic [2:0] op, input logic [15:0] addr,
                         input logic [15:0] wdata, input int lat_ptr, input int lat_data);
    logic [15:0] ptr, tgt, al, w, res, nw, exp_wd;
    logic [7:0]  b;
    logic [1:0]  exp_be;
    bit          ind, st, rsp;
    ind = (op == 3'd5) || (op == 3'd6);
    st  = (op == 3'd2) || (op == 3'd4) || (op == 3'd6);

    mem_valid[d] = 1'b1; mem_op[d] = op; mem_addr[d] = addr; mem_wdata[d] = wdata;
    dmem_resp[d] = 1'b0; dmem_rdata[d] = 16'($urandom);
    mid();
    check("start_stall", stall[d], 1);
    check("start_req", {dmem_read[d], dmem_write[d]}, 0);
    check("start_done", mem_done[d], 0);
    step(); scramble(d);

    tgt = addr;
    if (ind) begin
      ptr = word_at({addr[15:1], 1'b0});
      for (int k = 0; k <= lat_ptr; k++) begin
        rsp = (k == lat_ptr);
        dmem_resp[d]  = rsp;
        dmem_rdata[d] = rsp ? ptr : 16'($urandom);
        mid();
        check("ptr_read", dmem_read[d], 1);
        check("ptr_write", dmem_write[d], 0);
        check("ptr_addr", dmem_address[d], {addr[15:1], 1'b0});
        check("ptr_stall", stall[d], 1);
        check("ptr_done", mem_done[d], 0);
        step(); scramble(d);
      end
      for (int g = 0; g < gap_of(d); g++) begin
        dmem_resp[d]  = 1'($urandom);
        dmem_rdata[d] = 16'($urandom);
        mid();
        check("gap_req", {dmem_read[d], dmem_write[d]}, 0);
        check("gap_stall", stall[d], 1);
        check("gap_done", mem_done[d], 0);
        step(); scramble(d);
      end
      tgt = ptr;
    end

    al = {tgt[15:1], 1'b0};
    w  = word_at(al);
    if (op == 3'd3) begin
      b   = tgt[0] ? w[15:8] : w[7:0];
      res = {{8{b[7]}}, b};
    end else begin
      res = w;
    end
    exp_wd = (op == 3'd4) ? {wdata[7:0], wdata[7:0]} : wdata;
    exp_be = (op == 3'd4) ? (tgt[0] ? 2'b10 : 2'b01) : 2'b11;

    for (int k = 0; k <= lat_data; k++) begin
      rsp = (k == lat_data);
      dmem_resp[d]  = rsp;
      dmem_rdata[d] = rsp ? w : 16'($urandom);
      mid();
      check("data_read", dmem_read[d], !st);
      check("data_write", dmem_write[d], st);
      check("data_addr", dmem_address[d], al);
      if (st) begin
        check("data_wdata", dmem_wdata[d], exp_wd);
        check("data_be", dmem_byte_enable[d], exp_be);
      end else if (op != 3'd3) begin
        check("data_be", dmem_byte_enable[d], 2'b11);
      end
      check("data_stall", stall[d], !rsp);
      check("data_done", mem_done[d], rsp);
      if (rsp && !st) check("load_rdata", mem_rdata[d], res);
      step();
      if (!rsp) scramble(d);
    end

    if (op == 3'd4) begin
      nw = w;
      if (tgt[0]) nw[15:8] = wdata[7:0];
      else        nw[7:0]  = wdata[7:0];
      mem_model[al] = nw;
    end else if (st) begin
      mem_model[al] = wdata;
    end else begin
      hold_exp[d] = res;
    end

    mem_valid[d] = 1'b0; dmem_resp[d] = 1'b0;
    mid();
    check("idle_stall", stall[d], 0);
    check("idle_done", mem_done[d], 0);
    check("idle_req", {dmem_read[d], dmem_write[d]}, 0);
    check("idle_rdata", mem_rdata[d], hold_exp[d]);
    step();
  endtask

  initial begin
    for (int d = 0; d < 2; d++) begin
      reset[d] = 1'b1; mem_valid[d] = 1'b0; mem_op[d] = 3'd0; mem_addr[d] = 16'h0;
      mem_wdata[d] = 16'h0; dmem_resp[d] = 1'b0; dmem_rdata[d] = 16'h0; hold_exp[d] = 16'h0;
    end
    step(); step();
    for (int d = 0; d < 2; d++) begin
      check("rst_stall", stall[d], 0);
      check("rst_req", {dmem_read[d], dmem_write[d]}, 0);
      check("rst_done", mem_done[d], 0);
      check("rst_be", dmem_byte_enable[d], 2'b00);
      check("rst_rdata", mem_rdata[d], 16'h0000);
    end
    reset[0] = 1'b0; reset[1] = 1'b0;
    step();

    mem_model[16'h3000] = 16'hBEEF;
    run_txn(0, 3'd1, 16'h3001, 16'h0000, 0, 2);
    mem_model[16'h4000] = 16'h807F;
    run_txn(0, 3'd3, 16'h4001, 16'h0000, 0, 1);
    run_txn(0, 3'd3, 16'h4000, 16'h0000, 0, 0);
    run_txn(0, 3'd4, 16'h5001, 16'h12AB, 0, 2);
    mem_model[16'h6000] = 16'h7002;
    mem_model[16'h7002] = 16'h1234;
    run_txn(0, 3'd5, 16'h6000, 16'h0000, 1, 1);
    run_txn(1, 3'd5, 16'h6000, 16'h0000, 0, 0);

    for (int i = 0; i < 80; i++) begin
      run_txn(i % 2, 3'($urandom_range(1, 6)), 16'h3000 + 16'($urandom_range(0, 15)),
              16'($urandom), $urandom_range(0, 3), $urandom_range(0, 3));
    end

    // Make the hold register non-zero, then abandon an LDI in PTR with a response under reset.
    run_txn(0, 3'd1, 16'h3000, 16'h0000, 0, 0);
    mem_valid[0] = 1'b1; mem_op[0] = 3'd5; mem_addr[0] = 16'h6000;
    step();
    mem_valid[0] = 1'b0; reset[0] = 1'b1; dmem_resp[0] = 1'b1; dmem_rdata[0] = 16'h7002;
    step();
    reset[0] = 1'b0; dmem_resp[0] = 1'b0;
    hold_exp[0] = 16'h0000;
    mid();
    check("rstptr_req", {dmem_read[0], dmem_write[0]}, 0);
    check("rstptr_done", mem_done[0], 0);
    check("rstptr_rdata", mem_rdata[0], 16'h0000);
    check("rstptr_stall", stall[0], 0);
    step();
    run_txn(0, 3'd1, 16'h3001, 16'h0000, 0, 1);

    // Valid NONE, valid op 7, and invalid LDW all pass without a request.
    for (int d = 0; d < 2; d++) begin
      mem_valid[d] = 1'b1; mem_op[d] = 3'd0;
      mid();
      check("none_stall", stall[d], 0);
      check("none_req", {dmem_read[d], dmem_write[d]}, 0);
      check("none_done", mem_done[d], 0);
      step();
      mem_op[d] = 3'd7;
      mid();
      check("op7_stall", stall[d], 0);
      check("op7_req", {dmem_read[d], dmem_write[d]}, 0);
      step();
      mem_valid[d] = 1'b0; mem_op[d] = 3'd1;
      mid();
      check("inv_stall", stall[d], 0);
      check("inv_req", {dmem_read[d], dmem_write[d]}, 0);
      check("inv_done", mem_done[d], 0);
      step();
      mid();
      check("inv_after_req", {dmem_read[d], dmem_write[d]}, 0);
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- MEM-stage data-memory controller for the pipelined LC-3b. It is the producer side of the MEM/WB boundary.
- Takes the load/store operation, address and store data from EX/MEM and drives the data-memory request/response port.
- Performs the byte-lane handling for LDB/STB and the two-access indirection for LDI/STI.
- Delivers mem_rdata plus a one-cycle done strobe, and holds the pipeline via stall until the access completes.

Parameters:
- INDIRECT_GAP, 1: idle cycles (requests deasserted) between the LDI/STI pointer read and the data access. Legal range 0..3.

Ports:
- clk  in  1  pipeline clock
- reset  in  1  synchronous, active-high reset
- mem_valid  in  1  instruction in MEM stage is valid
- mem_op  in  3  0 NONE, 1 LDW, 2 STW, 3 LDB, 4 STB, 5 LDI, 6 STI; 7 treated as NONE
- mem_addr  in  16  effective address from EX
- mem_wdata  in  16  store data (SR value)
- dmem_read  out  1  data-memory read request
- dmem_write  out  1  data-memory write request
- dmem_address  out  16  request address
- dmem_wdata  out  16  write data
- dmem_byte_enable  out  2  write byte lanes, bit1 = high byte
- dmem_resp  in  1  access complete; read data valid this cycle
- dmem_rdata  in  16  read data
- mem_rdata  out  16  load result for the WB register
- mem_done  out  1  access completes this cycle
- stall  out  1  freeze IF..MEM pipeline registers

Behaviour:
- Reset: state IDLE; dmem_read, dmem_write, mem_done and stall are 0; dmem_byte_enable = 2'b00; internal op/addr/wdata/pointer registers and the mem_rdata hold register are 0.
- start = mem_valid && mem_op in 1..6. A valid NONE or an invalid instruction passes with no stall and no request.
- States: IDLE, PTR, GAP, DATA.
- IDLE:
  - On start, latch op, addr and wdata.
  - Next state is PTR for LDI/STI, otherwise DATA.
  - stall = 1 this cycle; no request is issued from IDLE.
- PTR:
  - dmem_read = 1, dmem_address = {addr[15:1],1'b0}.
  - On dmem_resp, latch the pointer = dmem_rdata, then go to GAP if INDIRECT_GAP > 0, else DATA.
- GAP:
  - Requests are deasserted.
  - A counter counts INDIRECT_GAP cycles, then the state goes to DATA.
- DATA:
  - Target address A = latched addr, or the pointer for LDI/STI.
  - Word ops: dmem_address = {A[15:1],0}, byte_enable = 2'b11. Read for LDW/LDI, write for STW/STI with dmem_wdata = wdata.
  - LDB: word-aligned read. Result is the sign-extended byte, taken from dmem_rdata[15:8] if A[0] = 1, else [7:0].
  - STB: dmem_address = {A[15:1],0}, dmem_wdata = {wdata[7:0], wdata[7:0]}, byte_enable = A[0] ? 2'b10 : 2'b01.
  - Requests stay asserted, with constant address and data, until dmem_resp.
  - On dmem_resp: mem_done = 1 (combinational, same cycle), stall = 0, next state IDLE.
  - For loads, mem_rdata = the processed dmem_rdata in that same cycle, and the value is captured into the hold register.
- stall = (IDLE && start) || (state != IDLE && !(DATA && dmem_resp)).
- Because the pipeline advances on the edge where mem_done = 1, a new instruction is present in IDLE on the following cycle. Back-to-back memory ops therefore cost at least 2 cycles each.
- mem_rdata outside the done cycle: the hold register (last load result). Stores leave the hold register unchanged.
- Misaligned word address: bit 0 is silently dropped; no exception.
- dmem_resp outside PTR/DATA is ignored.
- mem_valid/mem_op changing while the unit is busy is ignored; latched values are used.
- Reset asserted in any state: next cycle is IDLE with requests deasserted, even if dmem_resp arrives in the reset cycle. An in-flight access is abandoned with no done pulse.
- No combinational path from dmem_resp to dmem_read/dmem_write.

Test Plan:
- LDW at 0x3001, resp after 3 cycles with rdata 0xBEEF:
  - dmem_address = 0x3000 and read is held 3 cycles.
  - mem_done and mem_rdata = 0xBEEF occur on the resp cycle.
  - stall is 1 from the start cycle until the resp cycle, then 0.
- LDB at 0x4001 and at 0x4000, rdata 0x80 7F:
  - mem_rdata = 0xFF80 and 0x007F respectively.
- STB at 0x5001 with wdata 0x12AB:
  - dmem_wdata = 0xABAB, byte_enable = 2'b10, write held until resp.
- LDI at 0x6000 with INDIRECT_GAP = 1:
  - Pointer read at 0x6000 returns 0x7002.
  - Exactly 1 idle cycle follows.
  - Data read at 0x7002 returns 0x1234, giving mem_rdata 0x1234.
  - Repeat with INDIRECT_GAP = 0: no idle cycle.
- Reset asserted while in PTR, with dmem_resp the same cycle:
  - Next cycle is IDLE, all requests 0, no mem_done, mem_rdata = 0.
- mem_valid = 1 with op NONE, then mem_valid = 0 with op LDW:
  - No stall, no request, mem_done stays 0 in both cycles.
